// File: rtl/rs_age_issue.sv
// Reservation station with CDB wakeup, same-cycle bypass and oldest-ready-first issue
// (age matrix) onto ports that each accept a configurable set of FU types.
module rs_age_issue #(
   parameter int N_ENT  = 16,
   parameter int DISP_W = 2,
   parameter int ISS_W  = 2,
   parameter int CDB_W  = 2,
   parameter int XLEN   = 32,
   parameter int PRF_W  = 6,
   parameter int PL_W   = 64,
   parameter int FT_W   = 2,
   parameter logic [ISS_W*(2**FT_W)-1:0] PORT_MASK = {(ISS_W*(2**FT_W)){1'b1}}
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      squash,
   input  logic [DISP_W-1:0]         disp_valid,
   input  logic [DISP_W*PL_W-1:0]    disp_payload,
   input  logic [DISP_W*FT_W-1:0]    disp_ft,
   input  logic [DISP_W-1:0]         disp_a_rdy,
   input  logic [DISP_W-1:0]         disp_b_rdy,
   input  logic [DISP_W*XLEN-1:0]    disp_a,
   input  logic [DISP_W*XLEN-1:0]    disp_b,
   input  logic [CDB_W-1:0]          cdb_valid,
   input  logic [CDB_W*PRF_W-1:0]    cdb_tag,
   input  logic [CDB_W*XLEN-1:0]     cdb_data,
   input  logic [ISS_W-1:0]          port_busy,
   output logic [ISS_W-1:0]          iss_valid,
   output logic [ISS_W*PL_W-1:0]     iss_payload,
   output logic [ISS_W*XLEN-1:0]     iss_a,
   output logic [ISS_W*XLEN-1:0]     iss_b,
   output logic [$clog2(N_ENT):0]    free_cnt,
   output logic                      overflow_err
);
   localparam int NT = 2**FT_W;
   localparam int CW = $clog2(N_ENT) + 1;
   localparam int IW = $clog2(N_ENT);
   localparam int WW = (DISP_W > 1) ? $clog2(DISP_W) : 1;

   logic [N_ENT-1:0] valid_reg, a_rdy_reg, b_rdy_reg;
   logic [XLEN-1:0]  a_reg  [N_ENT];
   logic [XLEN-1:0]  b_reg  [N_ENT];
   logic [FT_W-1:0]  ft_reg [N_ENT];
   logic [PL_W-1:0]  pl_reg [N_ENT];
   logic [N_ENT-1:0] old_reg  [N_ENT];
   logic [N_ENT-1:0] old_next [N_ENT];
   logic [CW-1:0]    free_cnt_reg;
   logic             overflow_reg;

   // Returns {hit, data}; scanning downwards lets the lowest CDB way win on duplicate tags.
   function automatic logic [XLEN:0] cdb_lookup(input logic [CDB_W-1:0] v,
         input logic [CDB_W*PRF_W-1:0] tags, input logic [CDB_W*XLEN-1:0] data,
         input logic [PRF_W-1:0] tag);
      logic [XLEN:0] r;
      r = '0;
      for (int c = CDB_W-1; c >= 0; c--)
         if (v[c] && tags[c*PRF_W +: PRF_W] == tag) r = {1'b1, data[c*XLEN +: XLEN]};
      return r;
   endfunction

   logic [XLEN:0] wake_a [N_ENT];
   logic [XLEN:0] wake_b [N_ENT];
   logic [XLEN:0] byp_a  [DISP_W];
   logic [XLEN:0] byp_b  [DISP_W];

   genvar gi;
   for (gi = 0; gi < N_ENT; gi++) begin : g_wake
      assign wake_a[gi] = cdb_lookup(cdb_valid, cdb_tag, cdb_data, a_reg[gi][PRF_W-1:0]);
      assign wake_b[gi] = cdb_lookup(cdb_valid, cdb_tag, cdb_data, b_reg[gi][PRF_W-1:0]);
   end

   for (gi = 0; gi < DISP_W; gi++) begin : g_byp
      logic [XLEN:0] la, lb;
      assign la = cdb_lookup(cdb_valid, cdb_tag, cdb_data, disp_a[gi*XLEN +: PRF_W]);
      assign lb = cdb_lookup(cdb_valid, cdb_tag, cdb_data, disp_b[gi*XLEN +: PRF_W]);
      assign byp_a[gi] = disp_a_rdy[gi] ? {1'b1, disp_a[gi*XLEN +: XLEN]}
                       : (la[XLEN] ? la : {1'b0, disp_a[gi*XLEN +: XLEN]});
      assign byp_b[gi] = disp_b_rdy[gi] ? {1'b1, disp_b[gi*XLEN +: XLEN]}
                       : (lb[XLEN] ? lb : {1'b0, disp_b[gi*XLEN +: XLEN]});
   end

   // Allocation: only slots free at the start of the cycle are candidates.
   logic [N_ENT-1:0] wr_en;
   logic [WW-1:0]    wr_way [N_ENT];
   logic [CW-1:0]    n_disp;
   logic             drop, placed;
   always_comb begin
      wr_en  = '0;
      n_disp = '0;
      drop   = 1'b0;
      placed = 1'b0;
      for (int k = 0; k < N_ENT; k++) wr_way[k] = '0;
      for (int w = 0; w < DISP_W; w++) begin
         placed = 1'b0;
         if (disp_valid[w]) begin
            for (int k = 0; k < N_ENT; k++)
               if (!placed && !valid_reg[k] && !wr_en[k]) begin
                  wr_en[k]  = 1'b1;
                  wr_way[k] = WW'(w);
                  placed    = 1'b1;
               end
            if (placed) n_disp = n_disp + CW'(1);
            else        drop   = 1'b1;
         end
      end
   end

   // Issue select: per port, the eligible type-matching entry that nothing eligible is older than.
   logic [N_ENT-1:0] taken, cand;
   logic [ISS_W-1:0] pick_v;
   logic [IW-1:0]    pick_idx [ISS_W];
   logic [CW-1:0]    n_iss;
   logic             blocked;
   always_comb begin
      taken   = '0;
      cand    = '0;
      pick_v  = '0;
      n_iss   = '0;
      blocked = 1'b0;
      for (int p = 0; p < ISS_W; p++) pick_idx[p] = '0;
      for (int p = 0; p < ISS_W; p++) begin
         for (int i = 0; i < N_ENT; i++)
            cand[i] = valid_reg[i] & a_rdy_reg[i] & b_rdy_reg[i] & ~taken[i]
                      & PORT_MASK[p*NT + int'(ft_reg[i])];
         if (!port_busy[p] && !reset && !squash) begin
            for (int e = 0; e < N_ENT; e++) begin
               blocked = 1'b0;
               for (int j = 0; j < N_ENT; j++)
                  if (cand[j] && old_reg[j][e]) blocked = 1'b1;
               if (cand[e] && !blocked && !pick_v[p]) begin
                  pick_v[p]   = 1'b1;
                  pick_idx[p] = IW'(e);
                  taken[e]    = 1'b1;
                  n_iss       = n_iss + CW'(1);
               end
            end
         end
      end
   end

   for (gi = 0; gi < ISS_W; gi++) begin : g_out
      assign iss_valid[gi] = pick_v[gi];
      assign iss_payload[gi*PL_W +: PL_W] = pick_v[gi] ? pl_reg[pick_idx[gi]] : '0;
      assign iss_a[gi*XLEN +: XLEN]       = pick_v[gi] ? a_reg[pick_idx[gi]]  : '0;
      assign iss_b[gi*XLEN +: XLEN]       = pick_v[gi] ? b_reg[pick_idx[gi]]  : '0;
   end

   // A new entry is younger than every survivor; same-cycle writes order by way.
   for (gi = 0; gi < N_ENT; gi++) begin : g_age
      always_comb begin
         old_next[gi] = old_reg[gi];
         for (int j = 0; j < N_ENT; j++) begin
            if (wr_en[gi])
               old_next[gi][j] = wr_en[j] && (wr_way[gi] < wr_way[j]);
            else if (!valid_reg[gi] || taken[gi] || taken[j])
               old_next[gi][j] = 1'b0;
            else if (wr_en[j])
               old_next[gi][j] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || squash) begin
         valid_reg    <= '0;
         a_rdy_reg    <= '0;
         b_rdy_reg    <= '0;
         free_cnt_reg <= CW'(N_ENT);
         overflow_reg <= 1'b0;
         for (int k = 0; k < N_ENT; k++) old_reg[k] <= '0;
      end else begin
         for (int k = 0; k < N_ENT; k++) begin
            old_reg[k] <= old_next[k];
            if (wr_en[k]) begin
               valid_reg[k] <= 1'b1;
               a_rdy_reg[k] <= byp_a[wr_way[k]][XLEN];
               b_rdy_reg[k] <= byp_b[wr_way[k]][XLEN];
            end else if (taken[k]) begin
               valid_reg[k] <= 1'b0;
               a_rdy_reg[k] <= 1'b0;
               b_rdy_reg[k] <= 1'b0;
            end else if (valid_reg[k]) begin
               if (wake_a[k][XLEN]) a_rdy_reg[k] <= 1'b1;
               if (wake_b[k][XLEN]) b_rdy_reg[k] <= 1'b1;
            end
         end
         free_cnt_reg <= free_cnt_reg - n_disp + n_iss;
         overflow_reg <= drop;
      end
   end

   // Entry storage; an operand that is already data never gets overwritten by a CDB match.
   always_ff @(posedge clock) begin
      for (int k = 0; k < N_ENT; k++) begin
         if (wr_en[k]) begin
            a_reg[k]  <= byp_a[wr_way[k]][XLEN-1:0];
            b_reg[k]  <= byp_b[wr_way[k]][XLEN-1:0];
            ft_reg[k] <= disp_ft[int'(wr_way[k])*FT_W +: FT_W];
            pl_reg[k] <= disp_payload[int'(wr_way[k])*PL_W +: PL_W];
         end else if (valid_reg[k]) begin
            if (!a_rdy_reg[k] && wake_a[k][XLEN]) a_reg[k] <= wake_a[k][XLEN-1:0];
            if (!b_rdy_reg[k] && wake_b[k][XLEN]) b_reg[k] <= wake_b[k][XLEN-1:0];
         end
      end
   end

   assign free_cnt     = free_cnt_reg;
   assign overflow_err = overflow_reg;
endmodule

// File: tb/tb_rs_age_issue.sv
// Scoreboard bench: stimulus queues expected issues/status per cycle, a negedge monitor
// compares them against two instances (default port masks and a filtered one).
module tb_rs_age_issue;
   logic          clock, reset, squash;
   logic [1:0]    dv_m, dv_f, busy_m, busy_f;
   logic [127:0]  disp_payload;
   logic [3:0]    disp_ft;
   logic [1:0]    disp_a_rdy, disp_b_rdy;
   logic [63:0]   disp_a, disp_b;
   logic [1:0]    cdb_valid;
   logic [11:0]   cdb_tag;
   logic [63:0]   cdb_data;
   logic [1:0]    iv_m, iv_f;
   logic [127:0]  ip_m, ip_f;
   logic [63:0]   ia_m, ib_m, ia_f, ib_f;
   logic [4:0]    fc_m, fc_f;
   logic          ov_m, ov_f;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct { int cyc; int id; int port; logic [63:0] pl; logic [31:0] a; logic [31:0] b; } iss_t;
   typedef struct { int cyc; int id; int fc; logic ov; } st_t;
   iss_t iq[$];
   st_t  sq[$];

   rs_age_issue dut (
      .clock(clock), .reset(reset), .squash(squash), .disp_valid(dv_m),
      .disp_payload(disp_payload), .disp_ft(disp_ft), .disp_a_rdy(disp_a_rdy),
      .disp_b_rdy(disp_b_rdy), .disp_a(disp_a), .disp_b(disp_b), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .port_busy(busy_m), .iss_valid(iv_m),
      .iss_payload(ip_m), .iss_a(ia_m), .iss_b(ib_m), .free_cnt(fc_m), .overflow_err(ov_m));

   rs_age_issue #(.PORT_MASK(8'b0010_0001)) dut_f (
      .clock(clock), .reset(reset), .squash(squash), .disp_valid(dv_f),
      .disp_payload(disp_payload), .disp_ft(disp_ft), .disp_a_rdy(disp_a_rdy),
      .disp_b_rdy(disp_b_rdy), .disp_a(disp_a), .disp_b(disp_b), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .port_busy(busy_f), .iss_valid(iv_f),
      .iss_payload(ip_f), .iss_a(ia_f), .iss_b(ib_f), .free_cnt(fc_f), .overflow_err(ov_f));

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      squash = 1'b0; dv_m = '0; dv_f = '0; busy_m = '0; busy_f = '0;
      disp_payload = '0; disp_ft = '0; disp_a_rdy = '0; disp_b_rdy = '0;
      disp_a = '0; disp_b = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
   endtask

   task automatic set_way(input int w, input logic [63:0] pl, input logic [1:0] ft,
                          input logic ar, input logic [31:0] a, input logic br, input logic [31:0] b);
      disp_payload[w*64 +: 64] = pl;
      disp_ft[w*2 +: 2]        = ft;
      disp_a_rdy[w]            = ar;
      disp_a[w*32 +: 32]       = a;
      disp_b_rdy[w]            = br;
      disp_b[w*32 +: 32]       = b;
   endtask

   task automatic set_cdb(input int c, input logic [5:0] tag, input logic [31:0] data);
      cdb_valid[c]         = 1'b1;
      cdb_tag[c*6 +: 6]    = tag;
      cdb_data[c*32 +: 32] = data;
   endtask

   task automatic exp_iss(input int dc, input int id, input int port,
                          input logic [63:0] pl, input logic [31:0] a, input logic [31:0] b);
      iss_t e;
      e = '{cyc + dc, id, port, pl, a, b};
      iq.push_back(e);
   endtask

   task automatic exp_st(input int dc, input int id, input int fc, input logic ov);
      st_t e;
      e = '{cyc + dc, id, fc, ov};
      sq.push_back(e);
   endtask

   task automatic check_iss(input int id, input logic [1:0] v, input logic [127:0] pl,
                            input logic [63:0] a, input logic [63:0] b);
      logic [1:0] expm;
      int idx;
      expm = '0;
      foreach (iq[i]) if (iq[i].id == id && iq[i].cyc == cyc) expm[iq[i].port] = 1'b1;
      checks++;
      if (v !== expm) begin
         failures++;
         $display("FAIL iss_valid dut%0d cyc=%0d got=%b exp=%b", id, cyc, v, expm);
      end
      for (int p = 0; p < 2; p++) begin
         if (v[p] === 1'b1)
            $display("issue dut%0d cyc=%0d port=%0d pl=%h a=%h b=%h", id, cyc, p,
                     pl[p*64 +: 64], a[p*32 +: 32], b[p*32 +: 32]);
         idx = -1;
         foreach (iq[i]) if (idx < 0 && iq[i].id == id && iq[i].cyc == cyc && iq[i].port == p) idx = i;
         if (idx >= 0) begin
            if (v[p] === 1'b1) begin
               checks += 3;
               if (pl[p*64 +: 64] !== iq[idx].pl) begin
                  failures++;
                  $display("FAIL payload dut%0d cyc=%0d port=%0d got=%h exp=%h", id, cyc, p, pl[p*64 +: 64], iq[idx].pl);
               end
               if (a[p*32 +: 32] !== iq[idx].a) begin
                  failures++;
                  $display("FAIL iss_a dut%0d cyc=%0d port=%0d got=%h exp=%h", id, cyc, p, a[p*32 +: 32], iq[idx].a);
               end
               if (b[p*32 +: 32] !== iq[idx].b) begin
                  failures++;
                  $display("FAIL iss_b dut%0d cyc=%0d port=%0d got=%h exp=%h", id, cyc, p, b[p*32 +: 32], iq[idx].b);
               end
            end
            iq.delete(idx);
         end
      end
   endtask

   task automatic check_st();
      logic [4:0] fc;
      logic       ov;
      for (int i = sq.size() - 1; i >= 0; i--) begin
         if (sq[i].cyc <= cyc) begin
            fc = (sq[i].id == 0) ? fc_m : fc_f;
            ov = (sq[i].id == 0) ? ov_m : ov_f;
            checks++;
            if (sq[i].cyc != cyc || fc !== 5'(sq[i].fc) || ov !== sq[i].ov) begin
               failures++;
               $display("FAIL status dut%0d cyc=%0d free_cnt=%0d overflow=%b exp_free=%0d exp_ovf=%b",
                        sq[i].id, cyc, fc, ov, sq[i].fc, sq[i].ov);
            end
            sq.delete(i);
         end
      end
   endtask

   always @(negedge clock) begin
      check_iss(0, iv_m, ip_m, ia_m, ib_m);
      check_iss(1, iv_f, ip_f, ia_f, ib_f);
      check_st();
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      exp_st(0, 0, 16, 1'b0);
      exp_st(0, 1, 16, 1'b0);

      // ready pair: issues next cycle, way 0 on port 0
      set_way(0, 64'h101, 2'd0, 1'b1, 32'd5, 1'b1, 32'd7);
      set_way(1, 64'h102, 2'd0, 1'b1, 32'd5, 1'b1, 32'd7);
      dv_m = 2'b11;
      exp_iss(1, 0, 0, 64'h101, 32'd5, 32'd7);
      exp_iss(1, 0, 1, 64'h102, 32'd5, 32'd7);
      exp_st(1, 0, 14, 1'b0);
      exp_st(2, 0, 16, 1'b0);
      step(); clr(); step(); step();

      // operand a waits on tag 9, woken from CDB way 1
      set_way(0, 64'h201, 2'd0, 1'b0, 32'd9, 1'b1, 32'd7);
      dv_m = 2'b01;
      exp_st(1, 0, 15, 1'b0);
      step(); clr(); step();
      set_cdb(0, 6'd20, 32'hCD);
      set_cdb(1, 6'd9, 32'hAB);
      exp_iss(1, 0, 0, 64'h201, 32'hAB, 32'd7);
      step(); clr(); step(); step();

      // same-cycle bypass on both operands, dispatched on way 1 alone
      set_way(1, 64'h301, 2'd0, 1'b0, 32'd3, 1'b0, 32'd5);
      dv_m = 2'b10;
      set_cdb(0, 6'd3, 32'h11);
      set_cdb(1, 6'd5, 32'h55);
      exp_iss(1, 0, 0, 64'h301, 32'h11, 32'h55);
      step(); clr(); step(); step();

      // age order with A in a higher slot than the younger B and C
      set_way(0, 64'h400, 2'd0, 1'b0, 32'd30, 1'b1, 32'd0);
      set_way(1, 64'h401, 2'd0, 1'b0, 32'd30, 1'b1, 32'd0);
      dv_m = 2'b11;
      step(); clr();
      set_way(0, 64'h4A0, 2'd0, 1'b0, 32'd4, 1'b1, 32'd1);
      dv_m = 2'b01;
      set_cdb(0, 6'd30, 32'h30);
      exp_iss(1, 0, 0, 64'h400, 32'h30, 32'd0);
      exp_iss(1, 0, 1, 64'h401, 32'h30, 32'd0);
      step(); clr(); step();
      set_way(0, 64'h4B0, 2'd0, 1'b0, 32'd4, 1'b1, 32'd2);
      set_way(1, 64'h4C0, 2'd0, 1'b0, 32'd4, 1'b1, 32'd3);
      dv_m = 2'b11;
      step(); clr();
      set_way(0, 64'h4D0, 2'd0, 1'b1, 32'hD, 1'b1, 32'hD);
      dv_m = 2'b01;
      exp_iss(1, 0, 0, 64'h4D0, 32'hD, 32'hD);
      step(); clr(); step();
      set_cdb(0, 6'd4, 32'h44);
      set_cdb(1, 6'd4, 32'h77);
      exp_st(0, 0, 13, 1'b0);
      exp_iss(1, 0, 0, 64'h4A0, 32'h44, 32'd1);
      exp_iss(1, 0, 1, 64'h4B0, 32'h44, 32'd2);
      exp_iss(2, 0, 0, 64'h4C0, 32'h44, 32'd3);
      exp_st(2, 0, 15, 1'b0);
      exp_st(3, 0, 16, 1'b0);
      step(); clr(); step(); step(); step();

      // port filtering on the second instance: type 1 only goes to port 1
      set_way(0, 64'h501, 2'd1, 1'b1, 32'h51, 1'b1, 32'h52);
      set_way(1, 64'h502, 2'd1, 1'b1, 32'h53, 1'b1, 32'h54);
      dv_f = 2'b11;
      exp_st(1, 1, 14, 1'b0);
      step(); clr();
      busy_f = 2'b10;
      step(); clr();
      exp_iss(0, 1, 1, 64'h501, 32'h51, 32'h52);
      exp_iss(1, 1, 1, 64'h502, 32'h53, 32'h54);
      exp_st(2, 1, 16, 1'b0);
      step(); step(); step();

      // fill all entries, overflow one dispatch, then squash with everything ready
      for (int i = 0; i < 8; i++) begin
         set_way(0, 64'h600 + 64'(2*i), 2'd0, 1'b0, 32'd60, 1'b1, 32'd0);
         set_way(1, 64'h601 + 64'(2*i), 2'd0, 1'b0, 32'd60, 1'b1, 32'd0);
         dv_m = 2'b11;
         exp_st(1, 0, 14 - 2*i, 1'b0);
         step(); clr();
      end
      set_way(1, 64'h6FF, 2'd0, 1'b1, 32'd1, 1'b1, 32'd1);
      dv_m = 2'b10;
      exp_st(1, 0, 0, 1'b1);
      exp_st(2, 0, 0, 1'b0);
      step(); clr(); step();
      set_cdb(1, 6'd60, 32'h60);
      step(); clr();
      squash = 1'b1;
      set_way(0, 64'h700, 2'd0, 1'b1, 32'd1, 1'b1, 32'd1);
      dv_m = 2'b01;
      exp_st(1, 0, 16, 1'b0);
      exp_st(2, 0, 16, 1'b0);
      exp_st(1, 1, 16, 1'b0);
      step(); clr(); step(); step();
      step();

      checks++;
      if (iq.size() != 0) begin
         failures++;
         $display("FAIL pending_issues left=%0d required=0", iq.size());
      end
      checks++;
      if (sq.size() != 0) begin
         failures++;
         $display("FAIL pending_status left=%0d required=0", sq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
